fp16_seq_multiplier: RTL and testbench

- Sequential IEEE-754 half-precision multiplier for the float_MAC datapath.
- Produces the product operand that the fp16 adder accumulates. It is the producer side of the adder's operand interface.
- Uses an 11-step shift-add mantissa multiply, a single normalize step and truncation rounding, so its results are bit-compatible with the adder's truncating arithmetic.
- Denormals are flushed to zero. NaN is not distinguished from infinity.

---
 rtl/fp16_seq_multiplier.sv | 138 +++++++++++++
 tb/tb_fp16_seq_multiplier.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/fp16_seq_multiplier.sv
// Sequential fp16 multiplier: 11-step shift-add mantissa multiply, one normalize
// step, truncation. Denormals flush to zero; NaN is treated as infinity.
module fp16_seq_multiplier #(
  parameter int BIAS = 15
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] Product,
  output logic [1:0]  dbg_state_o
);

  // Handshake: START is sampled only in IDLE; an accepted request raises BUSY
  // on the accept edge, and exactly 13 edges later Product updates with a
  // one-cycle DONE while BUSY drops. START at any other time is dropped.
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM, S_OUT} state_t;

  state_t      state_q, state_d;
  logic        sign_q, sign_d;
  logic [4:0]  ea_q, ea_d, eb_q, eb_d;
  logic [10:0] ma_q, ma_d, mb_q, mb_d;
  logic [21:0] p_q, p_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] res_q, res_d;
  logic [15:0] product_q, product_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  logic [6:0]  e_raw;
  logic [9:0]  frac_sel;
  logic        e_under, e_over;
  logic [15:0] res_norm;

  // Exponent in 7-bit two's complement so underflow shows up as a set MSB.
  always_comb begin
    e_raw    = {2'b00, ea_q} + {2'b00, eb_q} - 7'(BIAS) + {6'd0, p_q[21]};
    frac_sel = p_q[21] ? p_q[20:11] : p_q[19:10];
    e_under  = e_raw[6] || (e_raw == 7'd0);
    e_over   = !e_raw[6] && (e_raw >= 7'd31);
    if (ea_q == 5'd0 || eb_q == 5'd0) begin
      res_norm = {sign_q, 15'h0000};
    end else if (ea_q == 5'd31 || eb_q == 5'd31) begin
      res_norm = {sign_q, 5'h1F, 10'h000};
    end else if (e_under) begin
      res_norm = {sign_q, 15'h0000};
    end else if (e_over) begin
      res_norm = {sign_q, 5'h1F, 10'h000};
    end else begin
      res_norm = {sign_q, e_raw[4:0], frac_sel};
    end
  end

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    ea_d      = ea_q;
    eb_d      = eb_q;
    ma_d      = ma_q;
    mb_d      = mb_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    product_d = product_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_MUL;
          sign_d  = A[15] ^ B[15];
          ea_d    = A[14:10];
          eb_d    = B[14:10];
          ma_d    = {|A[14:10], A[9:0]};
          mb_d    = {|B[14:10], B[9:0]};
          p_d     = 22'd0;
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
        end
      end
      S_MUL: begin
        if (mb_q[cnt_q]) p_d = p_q + ({11'd0, ma_q} << cnt_q);
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd10) state_d = S_NORM;
      end
      S_NORM: begin
        res_d   = res_norm;
        state_d = S_OUT;
      end
      S_OUT: begin
        product_d = res_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      sign_q    <= 1'b0;
      ea_q      <= 5'd0;
      eb_q      <= 5'd0;
      ma_q      <= 11'd0;
      mb_q      <= 11'd0;
      p_q       <= 22'd0;
      cnt_q     <= 4'd0;
      res_q     <= 16'h0000;
      product_q <= 16'h0000;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      ea_q      <= ea_d;
      eb_q      <= eb_d;
      ma_q      <= ma_d;
      mb_q      <= mb_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      product_q <= product_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign Product     = product_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fp16_seq_multiplier.sv
// Directed bench for fp16_seq_multiplier: vector table, async reset abort and
// continuous-START handshake sequence.
module tb_fp16_seq_multiplier;

  logic        CLK;
  logic        RESET;
  logic        START;
  logic [15:0] A, B;
  logic        BUSY, DONE;
  logic [15:0] Product;
  logic [1:0]  dbg_state;

  int checks;
  int errors;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];
  logic [15:0] exp_q[$];

  fp16_seq_multiplier #(.BIAS(15)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .Product(Product), .dbg_state_o(dbg_state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one multiply from IDLE and waits (bounded) for DONE.
  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp);
    int n;
    A = a; B = b; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    A = 16'($urandom_range(0, 65535));
    B = 16'($urandom_range(0, 65535));
    check({name, "_busy"}, {15'd0, BUSY}, 16'd1);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge CLK); #1;
      if (DONE) begin
        n = i;
        break;
      end
    end
    check({name, "_latency"}, 16'(n), 16'd13);
    check({name, "_product"}, Product, exp);
    check({name, "_busy_at_done"}, {15'd0, BUSY}, 16'd0);
  endtask

  initial begin
    logic [15:0] last_exp;
    logic [15:0] good_a[3];
    logic [15:0] good_b[3];
    int done_seen;

    checks = 0; errors = 0;
    RESET = 1'b1; START = 1'b0; A = 16'h0; B = 16'h0;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    check("reset_product", Product, 16'h0000);
    check("reset_busy", {15'd0, BUSY}, 16'd0);
    check("reset_done", {15'd0, DONE}, 16'd0);
    check("reset_state", {14'd0, dbg_state}, 16'd0);

    vecs.push_back('{"one_x_one",   16'h3C00, 16'h3C00, 16'h3C00});
    vecs.push_back('{"1p5_x_2",     16'h3E00, 16'h4000, 16'h4200});
    vecs.push_back('{"neg_1p5_sq",  16'hBE00, 16'h3E00, 16'hC080});
    vecs.push_back('{"trunc",       16'h3C01, 16'h3C01, 16'h3C02});
    vecs.push_back('{"zero_a",      16'h0000, 16'h4500, 16'h0000});
    vecs.push_back('{"neg_zero",    16'h8000, 16'h3C00, 16'h8000});
    vecs.push_back('{"inf_x_zero",  16'h7C00, 16'h0000, 16'h0000});
    vecs.push_back('{"inf_x_neg2",  16'h7C00, 16'hC000, 16'hFC00});
    vecs.push_back('{"overflow",    16'h7800, 16'h4000, 16'h7C00});
    vecs.push_back('{"underflow",   16'h0400, 16'h3800, 16'h0000});
    vecs.push_back('{"neg2_x_neg2", 16'hC000, 16'hC000, 16'h4400});
    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Leave a nonzero Product so the reset abort is visible.
    run_op("pre_reset", 16'h3E00, 16'h4000, 16'h4200);
    A = 16'h3C00; B = 16'h3C00; START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
    repeat (5) @(posedge CLK);
    #2 RESET = 1'b1;
    #1;
    check("abort_busy", {15'd0, BUSY}, 16'd0);
    check("abort_done", {15'd0, DONE}, 16'd0);
    check("abort_product", Product, 16'h0000);
    @(posedge CLK); #1 RESET = 1'b0;
    done_seen = 0;
    repeat (20) begin
      @(posedge CLK); #1;
      if (DONE) done_seen++;
    end
    check("abort_no_done", 16'(done_seen), 16'd0);
    run_op("after_reset", 16'h3E00, 16'h4000, 16'h4200);

    // START held high; good operands only on accept edges, junk otherwise.
    good_a[0] = 16'hBE00; good_b[0] = 16'h3E00; exp_q.push_back(16'hC080);
    good_a[1] = 16'h3C01; good_b[1] = 16'h3C01; exp_q.push_back(16'h3C02);
    good_a[2] = 16'h3C00; good_b[2] = 16'h3C00; exp_q.push_back(16'h3C00);
    last_exp = 16'h4200;
    for (int c = 0; c < 42; c++) begin
      START = 1'b1;
      if (c % 14 == 0) begin
        A = good_a[c / 14]; B = good_b[c / 14];
      end else begin
        A = 16'h7BFF ^ 16'(c); B = 16'h7A55 ^ 16'(c * 3);
      end
      @(posedge CLK); #1;
      if (c % 14 == 13) begin
        check($sformatf("hs_done_c%0d", c), {15'd0, DONE}, 16'd1);
        last_exp = exp_q.pop_front();
        check($sformatf("hs_product_c%0d", c), Product, last_exp);
      end else begin
        check($sformatf("hs_nodone_c%0d", c), {15'd0, DONE}, 16'd0);
        check($sformatf("hs_stable_c%0d", c), Product, last_exp);
      end
    end
    START = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
